// File: rtl/seg7scan.sv
// seg7scan: digit-scan controller for the timer's multiplexed 7-segment display.
//
// Ports:
//   CLK                       system clock, rising edge
//   RST                       synchronous active-high reset
//   EN                        scan enable; low blanks the display and parks the scan at digit 0
//   TIM_1_I/TIM_2_I/TIM_3_I   live digit values from the counter (TIM_3_I most significant)
//   UPD                       snapshot request level, held by the requester until UPD_ACK
//   UPD_ACK                   one-cycle pulse: snapshot taken
//   TIM_1/TIM_2/TIM_3         held digit values for the segment mux
//   OE_DIGIT                  digit select: 00=TIM_1, 01=TIM_2, 10=TIM_3
//   DIG_EN_N                  active-low digit common enables, bit d is digit d
//   FRAME                     one-cycle pulse at the start of each frame
//
// Build option: define SEG7SCAN_LZB_EN to blank leading zeros on digits 2 and 1.
module seg7scan #(
    parameter int DIV_W     = 16,
    parameter int SCAN_DIV  = 50000,
    parameter int BLANK_CYC = 64
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       EN,
    input  logic [3:0] TIM_1_I,
    input  logic [3:0] TIM_2_I,
    input  logic [3:0] TIM_3_I,
    input  logic       UPD,
    output logic       UPD_ACK,
    output logic [3:0] TIM_1,
    output logic [3:0] TIM_2,
    output logic [3:0] TIM_3,
    output logic [1:0] OE_DIGIT,
    output logic [2:0] DIG_EN_N,
    output logic       FRAME
);
    localparam logic [DIV_W-1:0] CNT_MAX = DIV_W'(SCAN_DIV - 1);
    localparam logic [DIV_W-1:0] CNT_BLK = DIV_W'(BLANK_CYC);

    logic [DIV_W-1:0] cnt;
    logic [1:0]       dig;
    logic             en_q;
    logic             slot_end;
    logic             frame_wrap;
    logic             capture;
    logic             lit;
    logic [2:0]       show;

    assign slot_end   = EN && cnt == CNT_MAX;
    assign frame_wrap = slot_end && dig == 2'd2;
    // The cycle right after an ACK never re-captures, so a requester that
    // drops UPD on seeing the ACK gets exactly one snapshot.
    assign capture    = UPD && !UPD_ACK && (frame_wrap || !EN);

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt     <= '0;
            dig     <= 2'd0;
            en_q    <= 1'b0;
            UPD_ACK <= 1'b0;
            FRAME   <= 1'b0;
            TIM_1   <= 4'd0;
            TIM_2   <= 4'd0;
            TIM_3   <= 4'd0;
        end else begin
            cnt     <= !EN || slot_end ? '0 : cnt + DIV_W'(1);
            dig     <= !EN ? 2'd0 : !slot_end ? dig : dig == 2'd2 ? 2'd0 : dig + 2'd1;
            en_q    <= EN;
            UPD_ACK <= capture;
            FRAME   <= frame_wrap;
            if (capture) begin
                TIM_1 <= TIM_1_I;
                TIM_2 <= TIM_2_I;
                TIM_3 <= TIM_3_I;
            end
        end
    end

    // en_q keeps the digit enables purely register-decoded; it tracks EN one
    // edge later, exactly when cnt/dig react to EN.
    assign lit = en_q && cnt >= CNT_BLK;

`ifdef SEG7SCAN_LZB_EN
    assign show = {TIM_3 != 4'd0, TIM_3 != 4'd0 || TIM_2 != 4'd0, 1'b1};
`else
    assign show = 3'b111;
`endif

    assign OE_DIGIT = dig;
    assign DIG_EN_N = ~({dig == 2'd2, dig == 2'd1, dig == 2'd0} & show & {3{lit}});
endmodule

// File: tb/tb_seg7scan.sv
// tb_seg7scan: scoreboard bench for seg7scan with SCAN_DIV=4, BLANK_CYC=1.
module tb_seg7scan;
    typedef struct packed {
        logic [1:0]  oe;
        logic [2:0]  den;
        logic        fr;
        logic        ack;
        logic [11:0] tim;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic [3:0] t1 = 4'd0;
    logic [3:0] t2 = 4'd0;
    logic [3:0] t3 = 4'd0;
    logic       upd = 1'b0;
    logic       upd_ack;
    logic [3:0] tim_1;
    logic [3:0] tim_2;
    logic [3:0] tim_3;
    logic [1:0] oe_digit;
    logic [2:0] dig_en_n;
    logic       frame;

    exp_t        q[$];
    int          total = 0;
    int          bad = 0;
    int          kk = 0;
    logic [11:0] snap = '0;
    logic        fr_m = 1'b0;
    logic        ack_m = 1'b0;
    logic        lit_m = 1'b0;

    always #5 clk = ~clk;

    seg7scan #(.DIV_W(8), .SCAN_DIV(4), .BLANK_CYC(1)) dut (
        .CLK(clk), .RST(rst), .EN(en),
        .TIM_1_I(t1), .TIM_2_I(t2), .TIM_3_I(t3),
        .UPD(upd), .UPD_ACK(upd_ack),
        .TIM_1(tim_1), .TIM_2(tim_2), .TIM_3(tim_3),
        .OE_DIGIT(oe_digit), .DIG_EN_N(dig_en_n), .FRAME(frame)
    );

    function automatic exp_t observed();
        return '{oe: oe_digit, den: dig_en_n, fr: frame, ack: upd_ack, tim: {tim_3, tim_2, tim_1}};
    endfunction

    // Expected enables from the slot position: slot k/4, cycle k%4 within it, first cycle blanked.
    function automatic logic [2:0] exp_den(int k, logic l, logic [11:0] s);
        logic [2:0] m;
        int d;
        d = (k / 4) % 3;
        m = 3'b111;
        if (l && (k % 4) >= 1) begin
            m[d] = 1'b0;
`ifdef SEG7SCAN_LZB_EN
            if (d == 2 && s[11:8] == 4'd0) m[2] = 1'b1;
            if (d == 1 && s[11:4] == 8'd0) m[1] = 1'b1;
`endif
        end
        return m;
    endfunction

    // Advance the reference model over the coming edge, queue its expectation, then clock.
    task automatic tick();
        exp_t e;
        if (rst) begin
            kk = 0;
            snap = '0;
            fr_m = 1'b0;
            ack_m = 1'b0;
            lit_m = 1'b0;
        end else begin
            ack_m = upd && (!en || kk % 12 == 11);
            fr_m = en && kk % 12 == 11;
            lit_m = en;
            kk = en ? kk + 1 : 0;
            if (ack_m) snap = {t3, t2, t1};
        end
        e = '{oe: 2'((kk / 4) % 3), den: exp_den(kk, lit_m, snap), fr: fr_m, ack: ack_m, tim: snap};
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        exp_t e;
        rst = 1'b1; en = 1'b1; upd = 1'b1; t1 = 4'd7; t2 = 4'd7; t3 = 4'd7;
        for (int i = 0; i < 2; i++) begin
            tick();
            e = q.pop_front();
            total++;
            if (observed() !== e) begin
                bad++;
                $display("FAIL reset cyc=%0d got=%h want=%h", i, observed(), e);
            end
        end
        rst = 1'b0; upd = 1'b0;
    endtask

    task automatic test_free_run();
        exp_t e;
        for (int i = 0; i < 26; i++) begin
            tick();
            e = q.pop_front();
            total++;
            if (observed() !== e) begin
                bad++;
                $display("FAIL free_run k=%0d got=%h want=%h", kk, observed(), e);
            end
        end
    endtask

    task automatic test_mid_frame_update();
        exp_t e;
        for (int i = 0; i < 12 && (kk / 4) % 3 != 1; i++) begin
            tick();
            e = q.pop_front();
            total++;
            if (observed() !== e) begin
                bad++;
                $display("FAIL mid_update_pre k=%0d got=%h want=%h", kk, observed(), e);
            end
        end
        t1 = 4'd3; t2 = 4'd5; t3 = 4'd7; upd = 1'b1;
        for (int i = 0; i < 14; i++) begin
            tick();
            if (ack_m) upd = 1'b0;
            e = q.pop_front();
            total++;
            if (observed() !== e) begin
                bad++;
                $display("FAIL mid_update k=%0d got=%h want=%h", kk, observed(), e);
            end
        end
        total++;
        if (upd !== 1'b0 || snap !== 12'h753) begin
            bad++;
            $display("FAIL mid_update_ack upd=%b snap=%h want upd=0 snap=753", upd, snap);
        end
    endtask

    task automatic test_reset_mid_scan();
        exp_t e;
        for (int i = 0; i < 12 && kk % 12 != 6; i++) begin
            tick();
            e = q.pop_front();
            total++;
            if (observed() !== e) begin
                bad++;
                $display("FAIL rst_mid_pre k=%0d got=%h want=%h", kk, observed(), e);
            end
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        e = q.pop_front();
        total++;
        if (observed() !== e) begin
            bad++;
            $display("FAIL rst_mid_reset got=%h want=%h", observed(), e);
        end
        for (int i = 0; i < 14; i++) begin
            tick();
            e = q.pop_front();
            total++;
            if (observed() !== e) begin
                bad++;
                $display("FAIL rst_mid_restart k=%0d got=%h want=%h", kk, observed(), e);
            end
        end
    endtask

    task automatic test_idle_capture();
        exp_t e;
        en = 1'b0; t1 = 4'd9; t2 = 4'd8; t3 = 4'd1; upd = 1'b1;
        tick();
        upd = 1'b0;
        e = q.pop_front();
        total++;
        if (observed() !== e) begin
            bad++;
            $display("FAIL idle_capture got=%h want=%h", observed(), e);
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            e = q.pop_front();
            total++;
            if (observed() !== e) begin
                bad++;
                $display("FAIL idle_hold cyc=%0d got=%h want=%h", i, observed(), e);
            end
        end
    endtask

    task automatic test_lzb();
        exp_t e;
        for (int p = 0; p < 2; p++) begin
            en = 1'b0; t1 = 4'd9; t2 = 4'd0; t3 = 4'(p); upd = 1'b1;
            tick();
            upd = 1'b0; en = 1'b1;
            e = q.pop_front();
            total++;
            if (observed() !== e) begin
                bad++;
                $display("FAIL lzb_load p=%0d got=%h want=%h", p, observed(), e);
            end
            for (int i = 0; i < 13; i++) begin
                tick();
                e = q.pop_front();
                total++;
                if (observed() !== e) begin
                    bad++;
                    $display("FAIL lzb p=%0d k=%0d got=%h want=%h", p, kk, observed(), e);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_mid_frame_update();
        test_reset_mid_scan();
        test_idle_capture();
        test_lzb();
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_left got=%0d want=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/seg7scan.md
# seg7scan

Digit-scan controller driving the multiplexed 7-segment display path of the timer. It produces the `OE_DIGIT` select and the held `TIM_1..TIM_3` digit values consumed by the segment mux/encoder, plus active-low digit common enables. Scan timing comes from a prescaler, with a blanking window at the start of each digit slot to prevent ghosting. New digit values are taken from the counter side only on a frame boundary, so the display never tears.

## Interface
- `DIV_W`, 16, prescaler counter width.
- `SCAN_DIV`, 50000, clock cycles per digit slot; 2 ≤ SCAN_DIV ≤ 2^DIV_W.
- `BLANK_CYC`, 64, blanked cycles at the start of each slot; 0 ≤ BLANK_CYC < SCAN_DIV.
- `CLK  in  1  system clock; all logic on rising edge`
- `RST  in  1  synchronous, active-high reset`
- `EN  in  1  scan enable`
- `TIM_1_I, TIM_2_I, TIM_3_I  in  4 each  live digit values from the counter (TIM_3_I most significant)`
- `UPD  in  1  snapshot request; level, held until UPD_ACK`
- `UPD_ACK  out  1  one-cycle pulse: snapshot taken`
- `TIM_1, TIM_2, TIM_3  out  4 each  held digit values to the segment mux`
- `OE_DIGIT  out  2  digit select: 00=TIM_1, 01=TIM_2, 10=TIM_3; 11 never driven`
- `DIG_EN_N  out  3  active-low digit common enables; bit d is digit d`
- `FRAME  out  1  one-cycle pulse at the start of each frame`

## Operation
- State: `cnt` (DIV_W bits, 0..SCAN_DIV-1), `dig` (0..2), snapshot registers, `UPD_ACK`, `FRAME`.
- EN=1: `cnt` increments each cycle. When `cnt`=SCAN_DIV-1:
  - `cnt` wraps to 0.
  - `dig` advances 0→1→2→0.
  - A 2→0 advance is a frame wrap.
- EN=0: `cnt` and `dig` held at 0. `DIG_EN_N`=111.
- `OE_DIGIT` = `dig`.
- `DIG_EN_N[d]` = 0 only when EN=1, `dig`=d and `cnt` ≥ BLANK_CYC. All other bits are 1. At most one bit is low.
- Snapshot rule:
  - If UPD=1 and either a frame wrap occurs this cycle or EN=0, then `TIM_x` ← `TIM_x_I` and `UPD_ACK`=1 on the next cycle.
  - Otherwise the `TIM_x` outputs hold their values.
  - UPD still high in the cycle after the ACK does not re-capture until the next qualifying event. The requester must drop UPD on seeing the ACK.
- `FRAME`=1 for the one cycle following each frame wrap. It does not pulse after reset or on EN rising.
- EN falling mid-slot: scan aborts immediately and blanks the display. EN rising restarts at digit 0, `cnt` 0, with a full blank window.

## Timing
- Reset values:
  - `cnt`=0, `dig`=0.
  - `OE_DIGIT`=00, `DIG_EN_N`=111.
  - `TIM_1`=`TIM_2`=`TIM_3`=0.
  - `UPD_ACK`=0, `FRAME`=0.
- RST wins over all other inputs. RST mid-operation returns to the reset state on the next edge and discards any pending UPD.
- All outputs are registered or decoded purely from registers. There is no combinational input-to-output path.
- Slot length is SCAN_DIV cycles; frame length is 3·SCAN_DIV cycles.
- `OE_DIGIT` changes on the same edge that `cnt` returns to 0, so the segment path settles inside the blank window.
- UPD→ACK latency:
  - At most 3·SCAN_DIV cycles while scanning.
  - Exactly 1 cycle when EN=0.
- UPD rising in the same cycle as a frame wrap is captured at that wrap. `UPD_ACK` and `FRAME` then pulse together.
- BLANK_CYC=0: a digit lights from `cnt`=0.

## Configuration
- `SEG7SCAN_LZB_EN`: leading-zero blanking.
- Defined:
  - `DIG_EN_N[2]` is held 1 while snapshot `TIM_3`=0.
  - `DIG_EN_N[1]` is held 1 while `TIM_3`=0 and `TIM_2`=0.
  - Digit 0 is never suppressed.
  - Scan timing, `OE_DIGIT` and `FRAME` are unchanged.
- Undefined: every digit lights in its slot regardless of value.

## Test plan
Bench uses SCAN_DIV=4 and BLANK_CYC=1.
- **Reset:** RST=1 for 2 cycles with EN=1 and UPD=1 → all outputs at reset values; no `UPD_ACK` or `FRAME` pulse.
- **Free run:** EN=1 from reset.
  - `OE_DIGIT` = 00×4, 01×4, 10×4, then repeats.
  - `DIG_EN_N` per slot = 111, then d-low ×3 (110/101/011).
  - `FRAME` pulses every 12 cycles.
- **Mid-frame update:** `TIM_1_I`/`TIM_2_I`/`TIM_3_I`=3/5/7 and UPD raised during digit 1.
  - `TIM_x` outputs stay 0 until the frame wrap.
  - Next cycle `TIM_x`=3/5/7, with `UPD_ACK` and `FRAME` both high for 1 cycle.
- **Idle capture:** EN=0, inputs 9/8/1, UPD=1 → next cycle `TIM_x`=9/8/1, `UPD_ACK`=1 for 1 cycle, `DIG_EN_N`=111.
- **Reset mid-scan:** RST pulsed while `dig`=1, `cnt`=2, with snapshot 3/5/7 → next cycle `OE_DIGIT`=00, `DIG_EN_N`=111, `TIM_x`=0; scan restarts with a full 12-cycle frame.
- **Leading-zero blanking:** snapshot 9/0/0 (TIM_1/TIM_2/TIM_3).
  - With `SEG7SCAN_LZB_EN`: `DIG_EN_N[2:1]` stay 1 through their slots.
  - Without it: they go low for cnt 1..3 of their slots.
  - Snapshot 9/0/1: with the macro, digits 1 and 2 both light.
